mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Param TIMEOUT, default 255: max cycles a granted request waits for RAM ACCESS before error release.
REQ-002 Param ERRWORD, default 32'hBAD1BAD1: value returned on error release.
REQ-003 CLK  in  1  single clock; all state on posedge CLK.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 dREN, dWEN  in  1 each  data read/write request from bus controller memory port.
REQ-006 daddr, dstore  in  32 each  data address / write data.
REQ-007 dload  out  32  data read result; dwait  out  1  data wait (0 = transfer done this cycle).
REQ-008 iREN  in  2  per-core instruction fetch request; iaddr  in  2x32  fetch addresses.
REQ-009 iload  out  2x32  fetched words; iwait  out  2  per-core wait (0 = done this cycle).
REQ-010 ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each  RAM request.
REQ-011 ramload  in  32  RAM read data; ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-012 err  out  1  sticky error flag.

Function
REQ-013 FSM states IDLE, DATA, INSTR; grant register g (1 bit) selects core in INSTR.
REQ-014 IDLE: dREN|dWEN -> DATA; else any iREN -> INSTR; else stay IDLE.
REQ-015 Data SHALL take priority over instruction fetch in IDLE, whenever both request.
REQ-016 Instruction grant round-robin: rr pointer (reset 0) names preferred core; iREN[rr] wins if set, else the other core; winner latched into g on IDLE->INSTR.
REQ-017 In IDLE all ram outputs 0, dwait=1, iwait=2'b11.
REQ-018 DATA: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins if both); else ramREN=1, ramWEN=0.
REQ-019 DATA with ramstate==ACCESS: dwait=0 and dload=ramload same cycle, next IDLE.
REQ-020 INSTR: ramREN=1, ramWEN=0, ramaddr=iaddr[g], ramstore=0; ACCESS -> iwait[g]=0, iload[g]=ramload same cycle, rr <= !g, next IDLE.
REQ-021 Outside the completing cycle dload and iload SHALL be 0; only the granted requester's wait ever drops.
REQ-022 Abort: requester deasserts its request(s) while in DATA/INSTR before ACCESS -> ram outputs 0 that cycle, next IDLE, no wait drop, rr unchanged.
REQ-023 Timeout counter: cleared on entry to DATA/INSTR, increments each non-ACCESS cycle; counter==TIMEOUT or ramstate==ERROR -> error release.
REQ-024 Error release: granted wait=0, corresponding load=ERRWORD, err<=1, next IDLE, rr advanced as for success.
REQ-025 err sticky until reset; subsequent requests serviced normally.
REQ-026 Latency: request seen in IDLE at cycle N; RAM request driven from cycle N+1; earliest completion N+1 if RAM reports ACCESS immediately.
REQ-027 One transfer per grant; requester still asserting after completion re-arbitrates through IDLE (min 1 idle cycle between transfers).

Reset
REQ-028 nRST low: state=IDLE, g=0, rr=0, counter=0, err=0, immediately, independent of CLK.
REQ-029 During/after reset outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=1, iwait=2'b11, dload=iload=0.
REQ-030 Reset asserted mid-transfer abandons it; no wait drop is generated for it.

Verification
REQ-031 Data read: dREN=1, daddr=0x100, RAM ACCESS 2 cycles after grant with ramload=0xCAFEF00D -> ramREN=1/ramaddr=0x100 from cycle 1, dwait=0, dload=0xCAFEF00D in cycle 3 only.
REQ-032 Collision: dWEN=1 (daddr=0x40, dstore=0x12345678) and iREN=2'b11 same cycle -> data write first (ramWEN=1), then core0 fetch, then core1 fetch; rr toggles 0->1->0.
REQ-033 Fairness: iREN=2'b11 held for 6 fetches, RAM ACCESS each cycle -> grants alternate 0,1,0,1,0,1; neither iwait drops twice consecutively.
REQ-034 Error: iREN[1]=1, ramstate=ERROR in INSTR -> iwait[1]=0, iload[1]=0xBAD1BAD1, err=1 and remains 1 through next successful transfer.
REQ-035 Timeout: TIMEOUT=4, dREN=1, ramstate held BUSY -> dwait=0 with dload=0xBAD1BAD1 exactly 5 cycles after grant, err=1.
REQ-036 Reset mid-read: nRST low in DATA -> ramREN=0, dwait=1 asynchronously; after release state IDLE, err=0, new request serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: one RAM port shared by a data port and two instruction-fetch
// ports. Data has priority over fetch; the fetch ports are granted round-robin.
// A transfer ends when RAM reports ACCESS or ERROR, when a timeout expires, or
// when the requester withdraws its request.
//
// Handshake: a requester holds its REN/WEN high until its wait output is 0 for
// one cycle. The transfer completes in that cycle, and the load output is valid
// only in that cycle. Dropping the request before completion abandons the
// transfer without a wait drop.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic [31:0]      dload,
  output logic             dwait,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0][31:0] iload,
  output logic [1:0]       iwait,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t      state, state_next;
  logic        g, g_next;
  logic        rr, rr_next;
  logic        err_next;
  logic [31:0] cnt, cnt_next;
  logic        ram_done;
  logic        ram_fail;

  assign state_dbg = state;

  // RAM status: a normal completion, or an error release (error or timeout).
  assign ram_done = (ramstate == RAM_ACCESS);
  assign ram_fail = (ramstate == RAM_ERROR) || (cnt == TIMEOUT);

  // State, grant, round-robin pointer, timeout counter and sticky error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      g     <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      g     <= g_next;
      rr    <= rr_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // Arbitration, RAM drive and completion/error/abort decisions.
  always_comb begin
    state_next = state;
    g_next     = g;
    rr_next    = rr;
    cnt_next   = cnt;
    err_next   = err;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    dload      = '0;
    dwait      = 1'b1;
    iload      = '0;
    iwait      = 2'b11;
    case (state)
      IDLE: begin
        // Counter is cleared here so it starts at 0 on entry to a transfer.
        cnt_next = '0;
        if (dREN || dWEN) begin
          state_next = DATA;
        end else if (iREN != 2'b00) begin
          state_next = INSTR;
          g_next     = iREN[rr] ? rr : ~rr;
        end
      end
      DATA: begin
        if (!(dREN || dWEN)) begin
          state_next = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          if (ram_done) begin
            dwait      = 1'b0;
            dload      = ramload;
            state_next = IDLE;
          end else if (ram_fail) begin
            dwait      = 1'b0;
            dload      = ERRWORD;
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 32'd1;
          end
        end
      end
      INSTR: begin
        if (!iREN[g]) begin
          state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[g];
          if (ram_done) begin
            iwait[g]   = 1'b0;
            iload[g]   = ramload;
            rr_next    = ~g;
            state_next = IDLE;
          end else if (ram_fail) begin
            iwait[g]   = 1'b0;
            iload[g]   = ERRWORD;
            rr_next    = ~g;
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 32'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then a
// randomized run, all shadowed by a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT_P = 4;
  localparam logic [31:0] ERRWORD_P = 32'hBAD1BAD1;

  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic             dREN = 1'b0, dWEN = 1'b0;
  logic [31:0]      daddr = '0, dstore = '0;
  logic [31:0]      dload;
  logic             dwait;
  logic [1:0]       iREN = 2'b00;
  logic [1:0][31:0] iaddr = '0;
  logic [1:0][31:0] iload;
  logic [1:0]       iwait;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore;
  logic [31:0]      ramload = '0;
  logic [1:0]       ramstate = 2'd0;
  logic             err;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.TIMEOUT(TIMEOUT_P), .ERRWORD(ERRWORD_P)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dload(dload), .dwait(dwait), .iREN(iREN),
    .iaddr(iaddr), .iload(iload), .iwait(iwait), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = data port, 2 = core 0, 3 = core 1.
  // age: cycles the current owner has waited without completion.
  // pref: core that wins when both cores fetch.
  int   owner = 0;
  int   age = 0;
  int   pref = 0;
  logic err_m = 1'b0;

  typedef struct {
    logic             ren;
    logic             wen;
    logic [31:0]      addr;
    logic [31:0]      store;
    logic [31:0]      dload;
    logic             dwait;
    logic [1:0]       iwait;
    logic [63:0]      iload;
    int               outcome; // 0 keep waiting, 1 abort, 2 done, 3 error release
  } exp_t;

  function automatic exp_t model_eval();
    exp_t e;
    int c;
    e.ren = 1'b0; e.wen = 1'b0; e.addr = '0; e.store = '0; e.dload = '0;
    e.dwait = 1'b1; e.iwait = 2'b11; e.iload = '0; e.outcome = 0;
    if (owner == 1) begin
      if (!(dREN || dWEN)) e.outcome = 1;
      else begin
        e.wen = dWEN; e.ren = !dWEN; e.addr = daddr; e.store = dstore;
        if (ramstate == 2'd2) begin
          e.dwait = 1'b0; e.dload = ramload; e.outcome = 2;
        end else if (ramstate == 2'd3 || age == int'(TIMEOUT_P)) begin
          e.dwait = 1'b0; e.dload = ERRWORD_P; e.outcome = 3;
        end
      end
    end else if (owner >= 2) begin
      c = owner - 2;
      if (!iREN[c]) e.outcome = 1;
      else begin
        e.ren = 1'b1; e.addr = iaddr[c];
        if (ramstate == 2'd2) begin
          e.iwait[c] = 1'b0; e.iload[c*32 +: 32] = ramload; e.outcome = 2;
        end else if (ramstate == 2'd3 || age == int'(TIMEOUT_P)) begin
          e.iwait[c] = 1'b0; e.iload[c*32 +: 32] = ERRWORD_P; e.outcome = 3;
        end
      end
    end
    return e;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model_upd
    exp_t m;
    int   no, na, np;
    logic ne;
    if (!nRST) begin
      owner <= 0; age <= 0; pref <= 0; err_m <= 1'b0;
    end else begin
      no = owner; na = age; np = pref; ne = err_m;
      if (owner == 0) begin
        na = 0;
        if (dREN || dWEN) no = 1;
        else if (iREN != 2'b00) no = iREN[pref] ? 2 + pref : 3 - pref;
      end else begin
        m = model_eval();
        if (m.outcome == 0) na = age + 1;
        else begin
          if (m.outcome >= 2 && owner >= 2) np = (owner == 2) ? 1 : 0;
          if (m.outcome == 3) ne = 1'b1;
          no = 0;
        end
      end
      owner <= no; age <= na; pref <= np; err_m <= ne;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negative edge: all outputs against the model.
  always @(negedge CLK) begin : compare
    exp_t e;
    e = model_eval();
    chk("m_ramREN",   64'(ramREN),   64'(e.ren));
    chk("m_ramWEN",   64'(ramWEN),   64'(e.wen));
    chk("m_ramaddr",  64'(ramaddr),  64'(e.addr));
    chk("m_ramstore", 64'(ramstore), 64'(e.store));
    chk("m_dwait",    64'(dwait),    64'(e.dwait));
    chk("m_dload",    64'(dload),    64'(e.dload));
    chk("m_iwait",    64'(iwait),    64'(e.iwait));
    chk("m_iload",    64'(iload),    e.iload);
    chk("m_err",      64'(err),      64'(err_m));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    dREN = 1'b0; dWEN = 1'b0; iREN = 2'b00; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    #1 nRST = 1'b0;
    #1;
    chk("rst_ramREN", 64'(ramREN), 64'd0);
    chk("rst_ramaddr", 64'(ramaddr), 64'd0);
    chk("rst_dwait", 64'(dwait), 64'd1);
    chk("rst_iwait", 64'(iwait), 64'd3);
    chk("rst_loads", 64'(iload) | 64'(dload), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick(); tick();
    nRST = 1'b1;

    // Data read, ACCESS two cycles after grant.
    tick(); dREN = 1'b1; daddr = 32'h100; ramstate = 2'd1; settle();
    chk("rd_c0_ramREN", 64'(ramREN), 64'd0);
    tick(); settle();
    chk("rd_c1_ramREN", 64'(ramREN), 64'd1);
    chk("rd_c1_ramaddr", 64'(ramaddr), 64'h100);
    chk("rd_c1_dwait", 64'(dwait), 64'd1);
    tick(); settle();
    chk("rd_c2_dwait", 64'(dwait), 64'd1);
    tick(); ramstate = 2'd2; ramload = 32'hCAFEF00D; settle();
    chk("rd_c3_dwait", 64'(dwait), 64'd0);
    chk("rd_c3_dload", 64'(dload), 64'hCAFEF00D);
    tick(); dREN = 1'b0; ramstate = 2'd0; settle();
    chk("rd_c4_dwait", 64'(dwait), 64'd1);
    chk("rd_c4_dload", 64'(dload), 64'd0);

    // Collision: data write first, then core 0, then core 1.
    tick();
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678; iREN = 2'b11;
    iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; ramstate = 2'd2; ramload = 32'h11112222;
    settle();
    tick(); settle();
    chk("col_wen", 64'(ramWEN), 64'd1);
    chk("col_ren", 64'(ramREN), 64'd0);
    chk("col_store", 64'(ramstore), 64'h12345678);
    chk("col_dwait", 64'(dwait), 64'd0);
    chk("col_iwait0", 64'(iwait), 64'd3);
    tick(); dWEN = 1'b0; settle();
    tick(); settle();
    chk("col_core0_addr", 64'(ramaddr), 64'h1000);
    chk("col_core0_iwait", 64'(iwait), 64'b10);
    chk("col_core0_iload", 64'(iload), 64'h00000000_11112222);
    tick(); settle();
    tick(); settle();
    chk("col_core1_addr", 64'(ramaddr), 64'h2000);
    chk("col_core1_iwait", 64'(iwait), 64'b01);
    chk("col_core1_iload", 64'(iload), 64'h11112222_00000000);

    // Fairness: both cores keep fetching, grants must alternate.
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k % 2));
    for (int k = 0; k < 12; k++) begin
      tick(); settle();
      if (iwait != 2'b11) begin
        if (exp_q.size() == 0) chk("fair_extra_grant", 64'(iwait), 64'd3);
        else chk("fair_grant", 64'(iwait[0] ? 1 : 0), 64'(exp_q.pop_front()));
      end
    end
    chk("fair_all_granted", 64'(exp_q.size()), 64'd0);
    tick(); iREN = 2'b00; settle();

    // Timeout: RAM stays BUSY, release 5 cycles after the grant cycle.
    tick(); dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1; settle();
    for (int k = 1; k <= 5; k++) begin
      tick(); settle();
      chk("to_dwait", 64'(dwait), (k == 5) ? 64'd0 : 64'd1);
      if (k == 5) chk("to_dload", 64'(dload), 64'hBAD1BAD1);
      chk("to_err_before", 64'(err), 64'd0);
    end
    tick(); dREN = 1'b0; settle();
    chk("to_err", 64'(err), 64'd1);

    do_reset();

    // Error from RAM on a core 1 fetch; err stays through a later success.
    tick(); iREN = 2'b10; iaddr[1] = 32'h3000; ramstate = 2'd3; settle();
    tick(); settle();
    chk("er_iwait", 64'(iwait), 64'b01);
    chk("er_iload", 64'(iload), 64'hBAD1BAD1_00000000);
    tick(); iREN = 2'b00; dREN = 1'b1; daddr = 32'h200; ramstate = 2'd2;
    ramload = 32'h55AA55AA; settle();
    chk("er_err_set", 64'(err), 64'd1);
    tick(); settle();
    chk("er_next_dload", 64'(dload), 64'h55AA55AA);
    chk("er_err_sticky", 64'(err), 64'd1);
    tick(); dREN = 1'b0; settle();

    // Reset in the middle of a read.
    tick(); dREN = 1'b1; daddr = 32'h400; ramstate = 2'd1; settle();
    tick(); settle();
    chk("mr_ramREN_before", 64'(ramREN), 64'd1);
    #1 nRST = 1'b0;
    #1;
    chk("mr_ramREN_async", 64'(ramREN), 64'd0);
    chk("mr_dwait_async", 64'(dwait), 64'd1);
    chk("mr_err_async", 64'(err), 64'd0);
    dREN = 1'b0;
    tick(); tick(); nRST = 1'b1; settle();
    tick(); dREN = 1'b1; daddr = 32'h500; ramstate = 2'd2; ramload = 32'h600DF00D; settle();
    chk("mr_idle_dwait", 64'(dwait), 64'd1);
    tick(); settle();
    chk("mr_new_dwait", 64'(dwait), 64'd0);
    chk("mr_new_dload", 64'(dload), 64'h600DF00D);
    tick(); dREN = 1'b0; settle();

    // Randomized traffic; the compare process does the checking.
    for (int k = 0; k < 3000; k++) begin
      tick();
      nRST = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) dWEN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) iREN = 2'($urandom_range(0, 3));
      daddr = $urandom; dstore = $urandom;
      iaddr[0] = $urandom; iaddr[1] = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
    end
    tick(); nRST = 1'b1; clear_inputs();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
